// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: two read ports, one write
// port, one issue port and the pending-writer count.
interface regfile_scoreboard_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;
   logic              Busy1;
   logic              Busy2;
   logic [ADDR_W-1:0] WriteRegister;
   logic [WIDTH-1:0]  WriteData;
   logic              RegWrite;
   logic [ADDR_W-1:0] IssueRegister;
   logic              IssueValid;
   logic [ADDR_W:0]   PendingCount;

   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
             IssueRegister, IssueValid,
      input  ReadData1, ReadData2, Busy1, Busy2, PendingCount
   );

   modport slave (
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
             IssueRegister, IssueValid,
      output ReadData1, ReadData2, Busy1, Busy2, PendingCount
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with async reads, one sync write port and a
// per-register busy scoreboard whose population count feeds the stall logic.
module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input logic           Clk,
   input logic           ResetN,
   regfile_scoreboard_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              wr_ok, iss_ok;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];
   logic              rd_busy [2];

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_C) && !(ZERO_REG && (a == '0));
   endfunction

   assign wr_ok  = bus.RegWrite   && addr_ok(bus.WriteRegister);
   assign iss_ok = bus.IssueValid && addr_ok(bus.IssueRegister);

   assign rd_addr[0] = bus.ReadRegister1;
   assign rd_addr[1] = bus.ReadRegister2;

   // A bypassed write normally shows its register as free, but a same-cycle
   // issue to that register is the newer producer, so busy stays visible.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         // NOTE: every output gets a default before any branch so no latch is inferred.
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (addr_ok(rd_addr[p])) begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (BYPASS && wr_ok && (rd_addr[p] == bus.WriteRegister)) begin
               rd_data[p] = bus.WriteData;
               rd_busy[p] = iss_ok && (bus.IssueRegister == rd_addr[p]);
            end
         end
      end
   end

   // Clear before set so an issue wins over a writeback to the same register.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[bus.WriteRegister] = 1'b0;
      if (iss_ok) busy_d[bus.IssueRegister] = 1'b1;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         // NOTE: this is a flop array, not a RAM macro, so every entry is reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep all state changing together at the edge.
         if (wr_ok) mem_q[bus.WriteRegister] <= bus.WriteData;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign bus.ReadData1    = rd_data[0];
   assign bus.ReadData2    = rd_data[1];
   assign bus.Busy1        = rd_busy[0];
   assign bus.Busy2        = rd_busy[1];
   assign bus.PendingCount = count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Four differently configured register files share one stimulus stream; a
// queue-fed monitor compares each against an array-based reference model.
module tb_regfile_scoreboard;
   localparam int NDUT = 4;
   localparam int CFG_W [NDUT] = '{32, 16, 32, 32};
   localparam int CFG_D [NDUT] = '{32, 24, 32, 32};
   localparam bit CFG_B [NDUT] = '{1'b1, 1'b0, 1'b0, 1'b1};
   localparam bit CFG_Z [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0};

   typedef struct {
      int          dut;
      string       tag;
      logic [31:0] rd1, rd2;
      logic        b1, b2;
      logic [5:0]  pc;
   } exp_t;

   logic        clk, rst_n;
   logic [4:0]  rr1, rr2, wa, ia;
   logic [31:0] wd;
   logic        we, iv;

   logic [31:0] o_rd1 [NDUT];
   logic [31:0] o_rd2 [NDUT];
   logic        o_b1  [NDUT];
   logic        o_b2  [NDUT];
   logic [5:0]  o_pc  [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      regfile_scoreboard_if #(.WIDTH(CFG_W[g]), .ADDR_W(5)) bus ();
      assign bus.ReadRegister1 = rr1;
      assign bus.ReadRegister2 = rr2;
      assign bus.WriteRegister = wa;
      assign bus.WriteData     = wd[CFG_W[g]-1:0];
      assign bus.RegWrite      = we;
      assign bus.IssueRegister = ia;
      assign bus.IssueValid    = iv;
      assign o_rd1[g] = 32'(bus.ReadData1);
      assign o_rd2[g] = 32'(bus.ReadData2);
      assign o_b1[g]  = bus.Busy1;
      assign o_b2[g]  = bus.Busy2;
      assign o_pc[g]  = bus.PendingCount;
      regfile_scoreboard #(
         .WIDTH(CFG_W[g]), .DEPTH(CFG_D[g]), .ADDR_W(5),
         .BYPASS(CFG_B[g]), .ZERO_REG(CFG_Z[g])
      ) dut (
         .Clk(clk), .ResetN(rst_n), .bus(bus)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain arrays of register contents and busy flags.
   logic [31:0] m_mem  [NDUT][32];
   bit          m_busy [NDUT][32];
   exp_t        exp_q[$];
   event        sample_ev;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic bit m_valid(input int d, input int a);
      return (a < CFG_D[d]) && !(CFG_Z[d] && a == 0);
   endfunction

   function automatic logic [31:0] m_mask(input int d);
      return 32'((64'd1 << CFG_W[d]) - 64'd1);
   endfunction

   task automatic m_read(input int d, input int a, output logic [31:0] data, output logic busy);
      data = '0;
      busy = 1'b0;
      if (m_valid(d, a)) begin
         data = m_mem[d][a];
         busy = m_busy[d][a];
         if (CFG_B[d] && we && m_valid(d, int'(wa)) && a == int'(wa)) begin
            data = wd & m_mask(d);
            busy = iv && (int'(ia) == a);
         end
      end
   endtask

   function automatic logic [5:0] m_pending(input int d);
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(m_busy[d][r]);
      return 6'(n);
   endfunction

   task automatic m_reset();
      for (int d = 0; d < NDUT; d++)
         for (int r = 0; r < 32; r++) begin
            m_mem[d][r]  = '0;
            m_busy[d][r] = 1'b0;
         end
   endtask

   task automatic m_clock();
      for (int d = 0; d < NDUT; d++) begin
         if (we && m_valid(d, int'(wa))) begin
            m_mem[d][wa]  = wd & m_mask(d);
            m_busy[d][wa] = 1'b0;
         end
         if (iv && m_valid(d, int'(ia))) m_busy[d][ia] = 1'b1;
      end
   endtask

   task automatic push_all(input string tag);
      exp_t e;
      for (int d = 0; d < NDUT; d++) begin
         e.dut = d;
         e.tag = tag;
         m_read(d, int'(rr1), e.rd1, e.b1);
         m_read(d, int'(rr2), e.rd2, e.b2);
         e.pc = m_pending(d);
         exp_q.push_back(e);
      end
      -> sample_ev;
   endtask

   // Monitor: samples the DUT 1 time unit after stimulus settles.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s d%0d ReadData1", e.tag, e.dut), o_rd1[e.dut], e.rd1);
            check($sformatf("%s d%0d ReadData2", e.tag, e.dut), o_rd2[e.dut], e.rd2);
            check($sformatf("%s d%0d Busy1", e.tag, e.dut), 32'(o_b1[e.dut]), 32'(e.b1));
            check($sformatf("%s d%0d Busy2", e.tag, e.dut), 32'(o_b2[e.dut]), 32'(e.b2));
            check($sformatf("%s d%0d PendingCount", e.tag, e.dut), 32'(o_pc[e.dut]), 32'(e.pc));
         end
      end
   end

   task automatic cycle(input bit w, input int wa_i, input logic [31:0] wd_i,
                        input bit v, input int ia_i, input int r1, input int r2,
                        input string tag);
      @(negedge clk);
      we  = w;
      wa  = 5'(wa_i);
      wd  = wd_i;
      iv  = v;
      ia  = 5'(ia_i);
      rr1 = 5'(r1);
      rr2 = 5'(r2);
      push_all(tag);
      @(posedge clk);
      if (rst_n) m_clock();
   endtask

   // Reset pulsed between edges and held across one edge with a write and an
   // issue pending, both of which must be discarded.
   task automatic mid_reset();
      #2;
      we = 1'b1; wa = 5'd5; wd = 32'hCAFEF00D; iv = 1'b1; ia = 5'd6;
      rr1 = 5'd5; rr2 = 5'd6;
      rst_n = 1'b0;
      m_reset();
      push_all("reset_async");
      @(posedge clk);
      #1;
      push_all("reset_held");
      #2;
      rst_n = 1'b1;
   endtask

   function automatic int pick();
      return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
   endfunction

   initial begin
      rst_n = 1'b0;
      we = 1'b0; iv = 1'b0; wa = '0; ia = '0; wd = '0; rr1 = '0; rr2 = '0;
      m_reset();
      #2;
      push_all("por");
      #4;
      rst_n = 1'b1;

      cycle(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, "wr_r5");
      cycle(0, 0, 32'h0, 0, 0, 5, 0, "rd_r5");
      mid_reset();
      cycle(0, 0, 32'h0, 0, 0, 5, 6, "post_reset");

      cycle(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "zero_wr_iss");
      cycle(0, 0, 32'h0, 0, 0, 0, 0, "zero_rd");
      cycle(1, 0, 32'h0, 0, 0, 0, 0, "zero_clear");

      cycle(1, 7, 32'h12345678, 0, 0, 7, 7, "bypass_r7");
      cycle(0, 0, 32'h0, 0, 0, 7, 7, "after_r7");

      cycle(0, 0, 32'h0, 1, 3, 3, 4, "iss_r3");
      cycle(0, 0, 32'h0, 1, 4, 3, 4, "iss_r4");
      cycle(1, 3, 32'h33333333, 1, 3, 3, 4, "wr_iss_r3");
      cycle(1, 4, 32'h44444444, 0, 0, 3, 4, "wr_r4");
      cycle(1, 3, 32'h55555555, 0, 0, 3, 4, "wr_r3");
      cycle(0, 0, 32'h0, 0, 0, 3, 4, "sb_done");

      cycle(1, 23, 32'h0000A5A5, 0, 0, 23, 23, "wr_r23");
      cycle(1, 30, 32'h0000BEEF, 1, 30, 23, 30, "wr_iss_r30");
      cycle(0, 0, 32'h0, 0, 0, 30, 23, "rd_r30");

      for (int n = 0; n < 10000; n++) begin
         cycle(($urandom_range(0, 9) < 6), pick(), $urandom(),
               ($urandom_range(0, 9) < 5), pick(), pick(), pick(), "rand");
      end

      @(negedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
